// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and helpers.
//   rgb12_t         : packed {R,G,B}, 4 bits per channel
//   grey4_to_rgb12  : replicate a 4-bit grey level onto all three channels
//   addr_width      : ROM address width for a given word count (minimum 1)
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default 640x480 active area
package vga_pkg;

    typedef logic [11:0] rgb12_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    function automatic rgb12_t grey4_to_rgb12(input logic [3:0] grey);
        return {grey, grey, grey};
    endfunction

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to keep sideband signals aligned with
// the pixel pipeline.
//   clk, rst : clock, synchronous active-high reset (all stages -> RESET_VAL)
//   en       : shift enable; stages hold when low
//   din      : value entering stage 0
//   dout     : value leaving the last stage (DEPTH enabled shifts after din)
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= RESET_VAL;
            end
        end else if (en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_reg[i] <= stage_reg[i-1];
            end
            stage_reg[0] <= din;
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/image_fetch.sv
// Read-side master for a 4-bit greyscale image ROM in a VGA pipeline.
// Stage 0 walks the ROM address incrementally from the timing generator's
// counters (no multiplier); stage 1 expands the returned pixel to 12-bit RGB.
// Sync and display-enable are delayed two pixel ticks to line up with rgb.
//   clk, rst          : clock, synchronous active-high reset
//   pix_en            : pixel tick; all state advances only when high
//   hcount, vcount    : screen position from the timing generator
//   active_in         : display enable from the timing generator
//   hsync_in/vsync_in : syncs from the timing generator
//   rom_addr          : ROM read address (registered)
//   rom_pixel         : ROM data, valid one clock after rom_addr
//   rgb               : {R,G,B} output colour
//   active_out, hsync_out, vsync_out : sidebands aligned to rgb
module image_fetch
    import vga_pkg::*;
#(
    parameter int       IMG_W      = 640,
    parameter int       IMG_H      = 480,
    parameter int       SCALE      = 1,
    parameter int       H_ACTIVE   = H_ACTIVE_DEF,
    parameter int       V_ACTIVE   = V_ACTIVE_DEF,
    parameter rgb12_t   BORDER_RGB = 12'h000,
    parameter logic     SYNC_IDLE  = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pix_en,
    input  logic [9:0]                             hcount,
    input  logic [9:0]                             vcount,
    input  logic                                   active_in,
    input  logic                                   hsync_in,
    input  logic                                   vsync_in,
    output logic [addr_width(IMG_W*IMG_H)-1:0]     rom_addr,
    input  logic [3:0]                             rom_pixel,
    output rgb12_t                                 rgb,
    output logic                                   active_out,
    output logic                                   hsync_out,
    output logic                                   vsync_out
);

    localparam int AW = addr_width(IMG_W*IMG_H);

    // Image window clipped to the active area, so an oversized image can
    // never drive the address walk past the visible rows or columns.
    localparam int IMG_W_PIX_I = (IMG_W*SCALE < H_ACTIVE) ? IMG_W*SCALE : H_ACTIVE;
    localparam int IMG_H_PIX_I = (IMG_H*SCALE < V_ACTIVE) ? IMG_H*SCALE : V_ACTIVE;

    localparam logic [9:0]    IMG_W_PIX = 10'(IMG_W_PIX_I);
    localparam logic [9:0]    IMG_H_PIX = 10'(IMG_H_PIX_I);
    localparam logic [9:0]    H_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [1:0]    SUB_LAST  = 2'(SCALE - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(IMG_W*IMG_H - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(IMG_W);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    logic [AW-1:0] row_base_reg;
    logic [1:0]    hsub_reg;
    logic [1:0]    vsub_reg;

    logic in_img;
    logic row_in_img;
    logic frame_start;
    logic line_start;
    logic line_end;

    assign row_in_img  = (vcount < IMG_H_PIX);
    assign in_img      = active_in && (hcount < IMG_W_PIX) && row_in_img;
    assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);
    assign line_start  = (hcount == 10'd0);
    assign line_end    = (hcount == H_LAST) && row_in_img;

    // Stage 0: address generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_base_reg <= '0;
            hsub_reg     <= '0;
            vsub_reg     <= '0;
            rom_addr     <= '0;
        end else if (pix_en) begin
            if (frame_start) begin
                row_base_reg <= '0;
                hsub_reg     <= '0;
                vsub_reg     <= '0;
                rom_addr     <= '0;
            end else begin
                if (line_start) begin
                    hsub_reg <= '0;
                    // Below the image the address parks on the last pixel
                    // instead of loading the (now past-the-end) row base.
                    if (row_in_img) begin
                        rom_addr <= row_base_reg;
                    end
                end else if (in_img) begin
                    if (hsub_reg == SUB_LAST) begin
                        hsub_reg <= '0;
                        if (rom_addr != ADDR_LAST) begin
                            rom_addr <= rom_addr + ADDR_ONE;
                        end
                    end else begin
                        hsub_reg <= hsub_reg + 2'd1;
                    end
                end

                // Each image row is repeated on SCALE screen lines.
                if (line_end) begin
                    if (vsub_reg == SUB_LAST) begin
                        vsub_reg     <= '0;
                        row_base_reg <= row_base_reg + ROW_STEP;
                    end else begin
                        vsub_reg <= vsub_reg + 2'd1;
                    end
                end
            end
        end
    end

    // One-tick delay of {active, in_img}, matching the ROM read latency.
    logic active_d1;
    logic in_img_d1;

    vga_delay_line #(
        .WIDTH     (2),
        .DEPTH     (1),
        .RESET_VAL (2'b00)
    ) u_img_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .din  ({active_in, in_img}),
        .dout ({active_d1, in_img_d1})
    );

    // Stage 1: colour expansion; blanking forces black.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= 12'h000;
        end else if (pix_en) begin
            if (in_img_d1) begin
                rgb <= grey4_to_rgb12(rom_pixel);
            end else if (active_d1) begin
                rgb <= BORDER_RGB;
            end else begin
                rgb <= 12'h000;
            end
        end
    end

    // Two-tick delay of the sideband bundle so it lands with rgb.
    logic [2:0] side_q;

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (2),
        .RESET_VAL ({1'b0, SYNC_IDLE, SYNC_IDLE})
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .din  ({active_in, hsync_in, vsync_in}),
        .dout (side_q)
    );

    assign active_out = side_q[2];
    assign hsync_out  = side_q[1];
    assign vsync_out  = side_q[0];

endmodule

// File: tb/tb_image_fetch.sv
// Directed bench for image_fetch. Two instances share one small timing
// generator (12 clocks x 6 lines, 8x4 active):
//   A: IMG 4x2, SCALE 1, border 12'h123
//   B: IMG 4x2, SCALE 2, border 12'h456
// Each ROM returns data within one clock of its address.
module tb_image_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        active_in;
    logic        hsync_in;
    logic        vsync_in;

    logic [2:0]  addr_a, addr_b;
    logic [3:0]  pix_a, pix_b;
    logic [11:0] rgb_a, rgb_b;
    logic        act_a, hs_a, vs_a;
    logic        act_b, hs_b, vs_b;

    always #5 clk = ~clk;

    image_fetch #(
        .IMG_W(4), .IMG_H(2), .SCALE(1), .H_ACTIVE(8), .V_ACTIVE(4),
        .BORDER_RGB(12'h123), .SYNC_IDLE(1'b1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hcount(hcount), .vcount(vcount),
        .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rom_addr(addr_a), .rom_pixel(pix_a), .rgb(rgb_a),
        .active_out(act_a), .hsync_out(hs_a), .vsync_out(vs_a)
    );

    image_fetch #(
        .IMG_W(4), .IMG_H(2), .SCALE(2), .H_ACTIVE(8), .V_ACTIVE(4),
        .BORDER_RGB(12'h456), .SYNC_IDLE(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hcount(hcount), .vcount(vcount),
        .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rom_addr(addr_b), .rom_pixel(pix_b), .rgb(rgb_b),
        .active_out(act_b), .hsync_out(hs_b), .vsync_out(vs_b)
    );

    // Image contents (all nonzero so image pixels differ from blanking).
    function automatic logic [3:0] rom_a(input int a);
        return 4'hA ^ 4'(a);
    endfunction

    function automatic logic [3:0] rom_b(input int a);
        return 4'(1 + 2 * a);
    endfunction

    // ROM models: data ready half a clock after the address settles.
    always @(negedge clk) begin
        pix_a <= rom_a(int'(addr_a));
        pix_b <= rom_b(int'(addr_b));
    end

    // Timing generator shape.
    function automatic bit tg_act(input int h, input int v);
        return (h < 8) && (v < 4);
    endfunction

    function automatic bit tg_hs(input int h);
        return !((h == 9) || (h == 10));
    endfunction

    function automatic bit tg_vs(input int v);
        return v != 5;
    endfunction

    // Expected address after the tick at screen position (h, v).
    function automatic int exp_addr_a(input int h, input int v);
        if (v < 2) return 4 * v + ((h < 4) ? h : 3);
        return 7;
    endfunction

    function automatic int exp_addr_b(input int h, input int v);
        if (v < 4) return 4 * (v / 2) + ((h < 8) ? h / 2 : 3);
        return 7;
    endfunction

    // Expected colour for screen pixel (h, v).
    function automatic int exp_rgb_a(input int h, input int v);
        logic [3:0] g;
        if (!tg_act(h, v)) return 0;
        if (h < 4 && v < 2) begin
            g = rom_a(4 * v + h);
            return int'({g, g, g});
        end
        return 32'h123;
    endfunction

    function automatic int exp_rgb_b(input int h, input int v);
        logic [3:0] g;
        if (!tg_act(h, v)) return 0;
        g = rom_b(4 * (v / 2) + h / 2);
        return int'({g, g, g});
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int h, v, ph, pv;
    bit pvalid;
    bit chk_en;

    task automatic check_reset(input string phase);
        check_val($sformatf("%s A addr", phase), 32'(addr_a), 0);
        check_val($sformatf("%s A rgb", phase), 32'(rgb_a), 0);
        check_val($sformatf("%s A active", phase), 32'(act_a), 0);
        check_val($sformatf("%s A hsync", phase), 32'(hs_a), 1);
        check_val($sformatf("%s A vsync", phase), 32'(vs_a), 1);
        check_val($sformatf("%s B addr", phase), 32'(addr_b), 0);
        check_val($sformatf("%s B rgb", phase), 32'(rgb_b), 0);
        check_val($sformatf("%s B hsync", phase), 32'(hs_b), 1);
    endtask

    task automatic check_outputs(input string phase);
        string t;
        int    e_rgb_a, e_rgb_b, e_act, e_hs, e_vs;
        t = $sformatf("%s h%0d v%0d", phase, h, v);
        if (pvalid) begin
            e_rgb_a = exp_rgb_a(ph, pv);
            e_rgb_b = exp_rgb_b(ph, pv);
            e_act   = int'(tg_act(ph, pv));
            e_hs    = int'(tg_hs(ph));
            e_vs    = int'(tg_vs(pv));
        end else begin
            e_rgb_a = 0;
            e_rgb_b = 0;
            e_act   = 0;
            e_hs    = 1;
            e_vs    = 1;
        end
        check_val({t, " A addr"}, 32'(addr_a), exp_addr_a(h, v));
        check_val({t, " B addr"}, 32'(addr_b), exp_addr_b(h, v));
        check_val({t, " A rgb"}, 32'(rgb_a), e_rgb_a);
        check_val({t, " B rgb"}, 32'(rgb_b), e_rgb_b);
        check_val({t, " A active"}, 32'(act_a), e_act);
        check_val({t, " A hsync"}, 32'(hs_a), e_hs);
        check_val({t, " A vsync"}, 32'(vs_a), e_vs);
        check_val({t, " B active"}, 32'(act_b), e_act);
        check_val({t, " B hsync"}, 32'(hs_b), e_hs);
        check_val({t, " B vsync"}, 32'(vs_b), e_vs);
    endtask

    // One pixel tick of `period` clocks; pix_en high on the first clock only.
    task automatic run_tick(input int period);
        hcount    = 10'(h);
        vcount    = 10'(v);
        active_in = tg_act(h, v);
        hsync_in  = tg_hs(h);
        vsync_in  = tg_vs(v);
        pix_en    = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        if (chk_en) check_outputs("tick");
        for (int i = 1; i < period; i++) begin
            @(posedge clk);
            #1;
            if (chk_en) check_outputs("hold");
        end
        ph     = h;
        pv     = v;
        pvalid = 1'b1;
        h++;
        if (h == 12) begin
            h = 0;
            v = (v == 5) ? 0 : v + 1;
        end
    endtask

    initial begin
        int budget;
        rst       = 1'b1;
        pix_en    = 1'b0;
        hcount    = '0;
        vcount    = '0;
        active_in = 1'b0;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst    = 1'b0;
        h      = 0;
        v      = 0;
        pvalid = 1'b0;
        chk_en = 1'b1;

        // Full frame, pixel tick on every clock.
        repeat (72) run_tick(1);
        // Full frame, pixel tick on every 4th clock.
        repeat (72) run_tick(4);
        // Run into line 1 until A has reached address 5, then reset.
        repeat (14) run_tick(1);
        check_val("pre-reset A addr", 32'(addr_a), 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("midline reset");
        rst    = 1'b0;
        pvalid = 1'b0;
        chk_en = 1'b0;

        // Address walk is meaningless until the next frame start.
        budget = 0;
        while (!(h == 0 && v == 0) && budget < 200) begin
            run_tick(1);
            budget++;
        end
        check_val("resync frame start reached", 32'(h + v), 0);
        chk_en = 1'b1;
        repeat (72) run_tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
